mem_stage: RTL and testbench
============================

# mem_stage

Memory-access pipeline stage between the EX/MEM register and the MEM/WB register. It performs data-memory loads and stores over a single-beat req/ack bus, with little-endian lane steering and sign/zero extension. While a bus access is outstanding it freezes upstream stages and inserts a bubble into MEM/WB. Non-memory instructions pass straight through with zero added latency.

## Interface
- TIMEOUT_CYCLES, 16: maximum number of REQ cycles without Ack before the access is aborted; 0 disables the timeout.
- Clk  in  1  clock; all state updates on the rising edge.
- Rst  in  1  reset, synchronous, active-high.
- in_Valid  in  1  EX/MEM slot holds a real instruction.
- in_RegWrite, in_MemToReg, in_MemRead, in_MemWrite  in  1 each  control bits from EX/MEM.
- in_MemSize  in  2  access size: 00 byte, 01 half, 10 word.
- in_MemSigned  in  1  sign-extend sub-word loads.
- in_ALUOut  in  32  effective address / ALU result.
- in_WriteData  in  32  store data.
- in_WriteRegAddr  in  5  destination register.
- MEM_RegWrite, MEM_MemToReg  out  1 each  to MEM/WB.
- MEM_ALUOut, MEM_ReadMemData  out  32 each  to MEM/WB.
- MEM_WriteRegAddr  out  5  to MEM/WB.
- Stall_Mem  out  1  hold PC, IF/ID, ID/EX and EX/MEM.
- DMem_Req, DMem_We  out  1 each  bus request / write enable (registered).
- DMem_Addr  out  32  word-aligned address (registered).
- DMem_Be  out  4  byte enables (registered).
- DMem_WData  out  32  lane-steered store data (registered).
- DMem_RData  in  32  read data, valid when DMem_Ack=1.
- DMem_Ack  in  1  access complete.
- Mem_Misalign  out  1  one-cycle pulse on a misaligned access.
- Mem_Err  out  1  sticky bus-timeout flag; cleared only by Rst.

## Operation
- FSM states: IDLE, REQ, DONE.
- **IDLE, no memory op** (in_Valid=0 or MemRead=MemWrite=0):
  - Outputs combinational pass-through.
  - MEM_RegWrite = in_Valid & in_RegWrite; MEM_ReadMemData = 0; Stall_Mem = 0.
- **IDLE, valid memory op, aligned:**
  - Latch the control bits, ALUOut, WriteRegAddr, size and signed.
  - Register bus outputs: Addr = {ALUOut[31:2],2'b00}, We = MemWrite, Be and WData steered.
  - Go to REQ. Stall_Mem = 1 and MEM_RegWrite = 0 this cycle.
- **Misalignment:** half with addr[0]=1, or word with addr[1:0]≠0.
  - No bus request is issued; Mem_Misalign pulses for one cycle.
  - The instruction retires as a bubble: MEM_RegWrite = 0, Stall_Mem = 0.
- **REQ:**
  - DMem_Req = 1 and is held until Ack. Stall_Mem = 1, MEM_RegWrite = 0.
  - On Ack: capture extracted/extended RData, drop Req at the next edge, go to DONE.
- **DONE:**
  - Stall_Mem = 0. Outputs come from the latched copy; MEM_ReadMemData = captured data (0 for stores).
  - Go to IDLE at the next edge, where upstream advances.
- **Store lanes:**
  - Byte: Be = 1<<addr[1:0], WData = {4{d[7:0]}}.
  - Half: Be = addr[1] ? 1100 : 0011, WData = {2{d[15:0]}}.
  - Word: Be = 1111.
- **Load extract:** select lane by addr; extend to 32 bits with sign when in_MemSigned=1, else zero.
- **Timeout:** a counter counts REQ cycles. When it reaches TIMEOUT_CYCLES without Ack:
  - Drop Req and set Mem_Err.
  - Go to DONE with MEM_ReadMemData = 0 and MEM_RegWrite forced 0.
- DMem_Ack outside REQ is ignored.

## Timing
- Non-memory op: 0 added cycles.
- Memory op, zero-wait Ack (Ack in the first REQ cycle): 3 cycles of stage occupancy (IDLE, REQ, DONE), i.e. 2 stall cycles. Each wait state adds 1 cycle.
- Req deasserts on the edge after Ack; back-to-back accesses therefore have at least one Req-low cycle between them.
- Reset values: state IDLE, DMem_Req/We = 0, DMem_Addr/WData = 0, Be = 0, Mem_Err = 0, Mem_Misalign = 0, latched registers 0, timeout counter 0.
- While Rst=1: Stall_Mem = 0 and MEM_RegWrite = 0.
- Rst during REQ: Req is low from the next edge; the in-flight access is abandoned with no writeback.

## Configuration
- MEM_SUBWORD_EN defined: byte and halfword access as above.
- MEM_SUBWORD_EN undefined:
  - in_MemSize and in_MemSigned are ignored; every access is a word access with Be = 1111.
  - Misalignment is addr[1:0]≠0.
  - The lane mux and extension logic are absent.

## Structure
- Package mem_pkg holds:
  - Size encodings MEM_SIZE_B/H/W.
  - FSM state encodings.
  - A default for TIMEOUT_CYCLES.
- Sub-module mem_lane_align (combinational) contains store steering, Be generation, load extract/extend and the misalignment check. It is instantiated once.

## Test plan
- ALU op with RegWrite=1, ALUOut=0x1234 → same cycle: MEM_ALUOut=0x1234, MEM_RegWrite=1, Stall_Mem=0, no Req.
- Word load at 0x100, Ack in the first REQ cycle, RData=0xDEADBEEF → Stall high 2 cycles; DONE shows ReadMemData=0xDEADBEEF, RegWrite=1.
- Signed byte load at 0x103, RData=0x80FFFFFF → 0xFFFFFF80; unsigned → 0x00000080.
- Half store of 0xA5A55A5A at 0x202 → Addr=0x200, Be=1100, WData=0x5A5A5A5A, We=1.
- Word load at 0x101 → Mem_Misalign pulse, no Req, MEM_RegWrite=0.
- No Ack with TIMEOUT_CYCLES=4 → Req high 4 cycles, Mem_Err=1 sticky, RegWrite=0.
- Rst asserted mid-REQ → Req low at the next edge, Mem_Err cleared.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared size/state encodings and defaults for the memory-access stage.
package mem_pkg;

    localparam logic [1:0] MEM_SIZE_B = 2'b00;
    localparam logic [1:0] MEM_SIZE_H = 2'b01;
    localparam logic [1:0] MEM_SIZE_W = 2'b10;

    localparam int MEM_TIMEOUT_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DONE = 2'b10
    } mem_state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Store steering, byte enables, load extract/extend and alignment check; purely combinational.
// Sub-word support only with MEM_SUBWORD_EN defined, otherwise word-only accesses.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] store_data,
    input  logic [31:0] load_data,
    output logic [3:0]  be,
    output logic [31:0] store_lanes,
    output logic [31:0] load_ext,
    output logic        misalign
);

`ifdef MEM_SUBWORD_EN
    logic [31:0] load_shift;
    logic [15:0] load_half;

    assign load_shift = load_data >> {addr_lo, 3'b000};
    assign load_half  = addr_lo[1] ? load_data[31:16] : load_data[15:0];

    always_comb begin
        be          = 4'b1111;
        store_lanes = store_data;
        load_ext    = load_data;
        misalign    = |addr_lo;
        case (size)
            MEM_SIZE_B: begin
                be          = 4'b0001 << addr_lo;
                store_lanes = {4{store_data[7:0]}};
                load_ext    = {{24{sign_ext & load_shift[7]}}, load_shift[7:0]};
                misalign    = 1'b0;
            end
            MEM_SIZE_H: begin
                be          = addr_lo[1] ? 4'b1100 : 4'b0011;
                store_lanes = {2{store_data[15:0]}};
                load_ext    = {{16{sign_ext & load_half[15]}}, load_half};
                misalign    = addr_lo[0];
            end
            default: begin
                // word (and the unused 2'b11 code) behave as full-word accesses
            end
        endcase
    end
`else
    logic unused_size_bits;

    assign unused_size_bits = ^{size, sign_ext};
    assign be               = 4'b1111;
    assign store_lanes      = store_data;
    assign load_ext         = load_data;
    assign misalign         = |addr_lo;
`endif

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: loads/stores over a single-beat req/ack bus; non-memory ops pass through combinationally.
// Stalls upstream and bubbles MEM/WB while an access is in flight (2 stall cycles minimum); MEM_SUBWORD_EN enables byte/half.
module mem_stage
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = MEM_TIMEOUT_DEFAULT
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        in_Valid,
    input  logic        in_RegWrite,
    input  logic        in_MemToReg,
    input  logic        in_MemRead,
    input  logic        in_MemWrite,
    input  logic [1:0]  in_MemSize,
    input  logic        in_MemSigned,
    input  logic [31:0] in_ALUOut,
    input  logic [31:0] in_WriteData,
    input  logic [4:0]  in_WriteRegAddr,
    output logic        MEM_RegWrite,
    output logic        MEM_MemToReg,
    output logic [31:0] MEM_ALUOut,
    output logic [31:0] MEM_ReadMemData,
    output logic [4:0]  MEM_WriteRegAddr,
    output logic        Stall_Mem,
    output logic        DMem_Req,
    output logic        DMem_We,
    output logic [31:0] DMem_Addr,
    output logic [3:0]  DMem_Be,
    output logic [31:0] DMem_WData,
    input  logic [31:0] DMem_RData,
    input  logic        DMem_Ack,
    output logic        Mem_Misalign,
    output logic        Mem_Err
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

    mem_state_t  state, state_nxt;
    logic        start, misalign_evt, mem_op, timeout_hit;
    logic        lat_regwrite, lat_memtoreg, lat_we, lat_signed, timed_out;
    logic [1:0]  lat_size;
    logic [31:0] lat_aluout, rdata_q;
    logic [4:0]  lat_wra;
    logic [CW-1:0] tcnt;

    logic [1:0]  al_addr, al_size;
    logic        al_signed, al_misalign;
    logic [3:0]  al_be;
    logic [31:0] al_store, al_load;

    assign mem_op      = in_Valid & (in_MemRead | in_MemWrite);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (tcnt == TO_LAST);

    // The single aligner sees the incoming op in IDLE and the latched op once the access is in flight.
    assign al_addr   = (state == ST_IDLE) ? in_ALUOut[1:0] : lat_aluout[1:0];
    assign al_size   = (state == ST_IDLE) ? in_MemSize     : lat_size;
    assign al_signed = (state == ST_IDLE) ? in_MemSigned   : lat_signed;

    mem_lane_align u_align (
        .addr_lo     (al_addr),
        .size        (al_size),
        .sign_ext    (al_signed),
        .store_data  (in_WriteData),
        .load_data   (DMem_RData),
        .be          (al_be),
        .store_lanes (al_store),
        .load_ext    (al_load),
        .misalign    (al_misalign)
    );

    always_comb begin
        state_nxt        = state;
        start            = 1'b0;
        misalign_evt     = 1'b0;
        Stall_Mem        = 1'b0;
        MEM_RegWrite     = 1'b0;
        MEM_MemToReg     = in_MemToReg;
        MEM_ALUOut       = in_ALUOut;
        MEM_WriteRegAddr = in_WriteRegAddr;
        MEM_ReadMemData  = '0;
        case (state)
            ST_IDLE: begin
                if (mem_op) begin
                    if (al_misalign) begin
                        misalign_evt = 1'b1;
                    end else begin
                        start     = 1'b1;
                        Stall_Mem = 1'b1;
                        state_nxt = ST_REQ;
                    end
                end else begin
                    MEM_RegWrite = in_Valid & in_RegWrite;
                end
            end
            ST_REQ: begin
                Stall_Mem = 1'b1;
                if (DMem_Ack || timeout_hit) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                MEM_RegWrite     = lat_regwrite & ~timed_out;
                MEM_MemToReg     = lat_memtoreg;
                MEM_ALUOut       = lat_aluout;
                MEM_WriteRegAddr = lat_wra;
                MEM_ReadMemData  = rdata_q;
                state_nxt        = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (Rst) begin
            Stall_Mem    = 1'b0;
            MEM_RegWrite = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state        <= ST_IDLE;
            DMem_Req     <= 1'b0;
            DMem_We      <= 1'b0;
            DMem_Addr    <= '0;
            DMem_Be      <= '0;
            DMem_WData   <= '0;
            Mem_Err      <= 1'b0;
            Mem_Misalign <= 1'b0;
            lat_regwrite <= 1'b0;
            lat_memtoreg <= 1'b0;
            lat_we       <= 1'b0;
            lat_signed   <= 1'b0;
            lat_size     <= '0;
            lat_aluout   <= '0;
            lat_wra      <= '0;
            rdata_q      <= '0;
            timed_out    <= 1'b0;
            tcnt         <= '0;
        end else begin
            state        <= state_nxt;
            Mem_Misalign <= misalign_evt;
            if (start) begin
                lat_regwrite <= in_RegWrite;
                lat_memtoreg <= in_MemToReg;
                lat_we       <= in_MemWrite;
                lat_signed   <= in_MemSigned;
                lat_size     <= in_MemSize;
                lat_aluout   <= in_ALUOut;
                lat_wra      <= in_WriteRegAddr;
                DMem_Req     <= 1'b1;
                DMem_We      <= in_MemWrite;
                DMem_Addr    <= {in_ALUOut[31:2], 2'b00};
                DMem_Be      <= al_be;
                DMem_WData   <= al_store;
                rdata_q      <= '0;
                timed_out    <= 1'b0;
                tcnt         <= '0;
            end
            if (state == ST_REQ) begin
                if (DMem_Ack) begin
                    DMem_Req <= 1'b0;
                    rdata_q  <= lat_we ? '0 : al_load;
                end else if (timeout_hit) begin
                    DMem_Req  <= 1'b0;
                    Mem_Err   <= 1'b1;
                    timed_out <= 1'b1;
                    rdata_q   <= '0;
                end else if (TIMEOUT_CYCLES != 0) begin
                    tcnt <= tcnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage (TIMEOUT_CYCLES=4); sub-word checks follow MEM_SUBWORD_EN.
module tb_mem_stage;
    import mem_pkg::*;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        in_Valid, in_RegWrite, in_MemToReg, in_MemRead, in_MemWrite, in_MemSigned;
    logic [1:0]  in_MemSize;
    logic [31:0] in_ALUOut, in_WriteData;
    logic [4:0]  in_WriteRegAddr;
    logic        MEM_RegWrite, MEM_MemToReg;
    logic [31:0] MEM_ALUOut, MEM_ReadMemData;
    logic [4:0]  MEM_WriteRegAddr;
    logic        Stall_Mem, DMem_Req, DMem_We, DMem_Ack, Mem_Misalign, Mem_Err;
    logic [31:0] DMem_Addr, DMem_WData, DMem_RData;
    logic [3:0]  DMem_Be;

    int n_cmp = 0;
    int n_err = 0;

    always #5 Clk = ~Clk;

    mem_stage #(.TIMEOUT_CYCLES(4)) dut (
        .Clk(Clk), .Rst(Rst),
        .in_Valid(in_Valid), .in_RegWrite(in_RegWrite), .in_MemToReg(in_MemToReg),
        .in_MemRead(in_MemRead), .in_MemWrite(in_MemWrite), .in_MemSize(in_MemSize),
        .in_MemSigned(in_MemSigned), .in_ALUOut(in_ALUOut), .in_WriteData(in_WriteData),
        .in_WriteRegAddr(in_WriteRegAddr),
        .MEM_RegWrite(MEM_RegWrite), .MEM_MemToReg(MEM_MemToReg), .MEM_ALUOut(MEM_ALUOut),
        .MEM_ReadMemData(MEM_ReadMemData), .MEM_WriteRegAddr(MEM_WriteRegAddr),
        .Stall_Mem(Stall_Mem), .DMem_Req(DMem_Req), .DMem_We(DMem_We), .DMem_Addr(DMem_Addr),
        .DMem_Be(DMem_Be), .DMem_WData(DMem_WData), .DMem_RData(DMem_RData), .DMem_Ack(DMem_Ack),
        .Mem_Misalign(Mem_Misalign), .Mem_Err(Mem_Err)
    );

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic set_idle;
        in_Valid = 0; in_RegWrite = 0; in_MemToReg = 0; in_MemRead = 0; in_MemWrite = 0;
        in_MemSize = MEM_SIZE_W; in_MemSigned = 0; in_ALUOut = 0; in_WriteData = 0;
        in_WriteRegAddr = 0; DMem_Ack = 0; DMem_RData = 0;
    endtask

    task automatic set_op(input logic rd, input logic wr, input logic rw, input logic [1:0] sz,
                          input logic sg, input logic [31:0] a, input logic [31:0] wd,
                          input logic [4:0] ra);
        in_Valid = 1; in_MemRead = rd; in_MemWrite = wr; in_RegWrite = rw; in_MemToReg = rd;
        in_MemSize = sz; in_MemSigned = sg; in_ALUOut = a; in_WriteData = wd; in_WriteRegAddr = ra;
    endtask

    // Called right after driving a memory op in an IDLE cycle; returns in the DONE cycle.
    task automatic run_access(input logic [31:0] rdata, input int waits, output int stalls, output int reqs);
        stalls = 0; reqs = 0;
        #2; stalls += int'(Stall_Mem);
        for (int i = 0; i <= waits; i++) begin
            tick; #2;
            stalls += int'(Stall_Mem);
            reqs   += int'(DMem_Req);
            if (i == waits) begin DMem_Ack = 1; DMem_RData = rdata; end
        end
        tick; DMem_Ack = 0; DMem_RData = 32'h0BAD_0BAD; #2;
    endtask

    task automatic test_reset;
        Rst = 1; set_idle;
        set_op(1, 0, 1, MEM_SIZE_W, 0, 32'h100, 0, 5'd3);
        tick; tick; #2;
        n_cmp++; if (Stall_Mem !== 1'b0) begin n_err++; $display("FAIL reset_stall got=%b want=0", Stall_Mem); end
        n_cmp++; if (MEM_RegWrite !== 1'b0) begin n_err++; $display("FAIL reset_regwrite got=%b want=0", MEM_RegWrite); end
        n_cmp++; if (DMem_Req !== 1'b0) begin n_err++; $display("FAIL reset_req got=%b want=0", DMem_Req); end
        n_cmp++; if (DMem_Be !== 4'b0) begin n_err++; $display("FAIL reset_be got=%b want=0000", DMem_Be); end
        n_cmp++; if (DMem_Addr !== 32'h0) begin n_err++; $display("FAIL reset_addr got=%h want=0", DMem_Addr); end
        n_cmp++; if (Mem_Err !== 1'b0 || Mem_Misalign !== 1'b0) begin n_err++; $display("FAIL reset_flags got=%b%b want=00", Mem_Err, Mem_Misalign); end
        set_idle; Rst = 0;
        tick;
    endtask

    task automatic test_passthrough;
        set_op(0, 0, 1, MEM_SIZE_W, 0, 32'h1234, 32'hFFFF, 5'd7); #2;
        n_cmp++; if (MEM_ALUOut !== 32'h1234) begin n_err++; $display("FAIL pt_aluout got=%h want=1234", MEM_ALUOut); end
        n_cmp++; if (MEM_RegWrite !== 1'b1) begin n_err++; $display("FAIL pt_regwrite got=%b want=1", MEM_RegWrite); end
        n_cmp++; if (Stall_Mem !== 1'b0) begin n_err++; $display("FAIL pt_stall got=%b want=0", Stall_Mem); end
        n_cmp++; if (MEM_WriteRegAddr !== 5'd7 || MEM_ReadMemData !== 32'h0) begin n_err++; $display("FAIL pt_wra_rd got=%0d/%h want=7/0", MEM_WriteRegAddr, MEM_ReadMemData); end
        tick; #2;
        n_cmp++; if (DMem_Req !== 1'b0) begin n_err++; $display("FAIL pt_noreq got=%b want=0", DMem_Req); end
        in_Valid = 0; #1;
        n_cmp++; if (MEM_RegWrite !== 1'b0) begin n_err++; $display("FAIL pt_invalid_rw got=%b want=0", MEM_RegWrite); end
        tick; set_idle;
    endtask

    task automatic test_word_load;
        int st, rq;
        set_op(1, 0, 1, MEM_SIZE_W, 0, 32'h100, 0, 5'd5); #1;
        n_cmp++; if (MEM_RegWrite !== 1'b0 || Stall_Mem !== 1'b1) begin n_err++; $display("FAIL wl_issue got rw=%b st=%b want rw=0 st=1", MEM_RegWrite, Stall_Mem); end
        run_access(32'hDEADBEEF, 0, st, rq);
        n_cmp++; if (st !== 2) begin n_err++; $display("FAIL wl_stalls got=%0d want=2", st); end
        n_cmp++; if (rq !== 1) begin n_err++; $display("FAIL wl_reqcycles got=%0d want=1", rq); end
        n_cmp++; if (MEM_ReadMemData !== 32'hDEADBEEF) begin n_err++; $display("FAIL wl_data got=%h want=deadbeef", MEM_ReadMemData); end
        n_cmp++; if (MEM_RegWrite !== 1'b1 || MEM_MemToReg !== 1'b1 || Stall_Mem !== 1'b0) begin n_err++; $display("FAIL wl_done_ctl got=%b%b%b want=110", MEM_RegWrite, MEM_MemToReg, Stall_Mem); end
        n_cmp++; if (DMem_Req !== 1'b0 || DMem_Addr !== 32'h100 || DMem_We !== 1'b0 || DMem_Be !== 4'hF) begin n_err++; $display("FAIL wl_bus got req=%b addr=%h we=%b be=%b want 0/100/0/1111", DMem_Req, DMem_Addr, DMem_We, DMem_Be); end
        n_cmp++; if (MEM_WriteRegAddr !== 5'd5) begin n_err++; $display("FAIL wl_wra got=%0d want=5", MEM_WriteRegAddr); end
        tick; set_idle;
    endtask

    task automatic test_wait_states;
        int st, rq;
        set_op(1, 0, 1, MEM_SIZE_W, 0, 32'h180, 0, 5'd9);
        run_access(32'h13572468, 2, st, rq);
        n_cmp++; if (st !== 4 || rq !== 3) begin n_err++; $display("FAIL ws_cycles got stall=%0d req=%0d want 4/3", st, rq); end
        n_cmp++; if (MEM_ReadMemData !== 32'h13572468) begin n_err++; $display("FAIL ws_data got=%h want=13572468", MEM_ReadMemData); end
        tick; set_idle;
    endtask

    task automatic test_subword;
        int st, rq;
`ifdef MEM_SUBWORD_EN
        set_op(1, 0, 1, MEM_SIZE_B, 1, 32'h103, 0, 5'd1);
        run_access(32'h80FFFFFF, 0, st, rq);
        n_cmp++; if (MEM_ReadMemData !== 32'hFFFFFF80) begin n_err++; $display("FAIL sb_signed got=%h want=ffffff80", MEM_ReadMemData); end
        n_cmp++; if (DMem_Be !== 4'b1000) begin n_err++; $display("FAIL sb_be got=%b want=1000", DMem_Be); end
        tick; set_op(1, 0, 1, MEM_SIZE_B, 0, 32'h103, 0, 5'd1);
        run_access(32'h80FFFFFF, 0, st, rq);
        n_cmp++; if (MEM_ReadMemData !== 32'h00000080) begin n_err++; $display("FAIL sb_unsigned got=%h want=00000080", MEM_ReadMemData); end
        tick; set_op(1, 0, 1, MEM_SIZE_H, 1, 32'h102, 0, 5'd2);
        run_access(32'h80017FFF, 0, st, rq);
        n_cmp++; if (MEM_ReadMemData !== 32'hFFFF8001) begin n_err++; $display("FAIL sh_signed got=%h want=ffff8001", MEM_ReadMemData); end
        tick; set_op(0, 1, 0, MEM_SIZE_H, 0, 32'h202, 32'hA5A55A5A, 5'd0);
        run_access(32'h0, 0, st, rq);
        n_cmp++; if (DMem_Addr !== 32'h200 || DMem_Be !== 4'b1100 || DMem_We !== 1'b1) begin n_err++; $display("FAIL hs_bus got addr=%h be=%b we=%b want 200/1100/1", DMem_Addr, DMem_Be, DMem_We); end
        n_cmp++; if (DMem_WData !== 32'h5A5A5A5A) begin n_err++; $display("FAIL hs_wdata got=%h want=5a5a5a5a", DMem_WData); end
        n_cmp++; if (MEM_ReadMemData !== 32'h0 || MEM_RegWrite !== 1'b0) begin n_err++; $display("FAIL hs_wb got=%h/%b want=0/0", MEM_ReadMemData, MEM_RegWrite); end
        tick; set_op(1, 0, 1, MEM_SIZE_H, 0, 32'h201, 0, 5'd2); #2;
        n_cmp++; if (Stall_Mem !== 1'b0) begin n_err++; $display("FAIL hmis_stall got=%b want=0", Stall_Mem); end
        tick; set_idle; #2;
        n_cmp++; if (Mem_Misalign !== 1'b1 || DMem_Req !== 1'b0) begin n_err++; $display("FAIL hmis_pulse got mis=%b req=%b want 1/0", Mem_Misalign, DMem_Req); end
`else
        set_op(1, 0, 1, MEM_SIZE_B, 1, 32'h100, 0, 5'd1);
        run_access(32'h80FFFFFF, 0, st, rq);
        n_cmp++; if (MEM_ReadMemData !== 32'h80FFFFFF) begin n_err++; $display("FAIL wo_load got=%h want=80ffffff", MEM_ReadMemData); end
        tick; set_op(0, 1, 0, MEM_SIZE_H, 0, 32'h200, 32'hA5A55A5A, 5'd0);
        run_access(32'h0, 0, st, rq);
        n_cmp++; if (DMem_Be !== 4'b1111 || DMem_WData !== 32'hA5A55A5A || DMem_We !== 1'b1) begin n_err++; $display("FAIL wo_store got be=%b wd=%h we=%b want 1111/a5a55a5a/1", DMem_Be, DMem_WData, DMem_We); end
        tick; set_op(1, 0, 1, MEM_SIZE_B, 0, 32'h103, 0, 5'd1); #2;
        n_cmp++; if (Stall_Mem !== 1'b0) begin n_err++; $display("FAIL wo_mis_stall got=%b want=0", Stall_Mem); end
        tick; set_idle; #2;
        n_cmp++; if (Mem_Misalign !== 1'b1 || DMem_Req !== 1'b0) begin n_err++; $display("FAIL wo_mis_pulse got mis=%b req=%b want 1/0", Mem_Misalign, DMem_Req); end
`endif
        tick; set_idle;
    endtask

    task automatic test_misalign;
        set_op(1, 0, 1, MEM_SIZE_W, 0, 32'h101, 0, 5'd4); #2;
        n_cmp++; if (MEM_RegWrite !== 1'b0 || Stall_Mem !== 1'b0) begin n_err++; $display("FAIL mis_bubble got rw=%b st=%b want 0/0", MEM_RegWrite, Stall_Mem); end
        tick; set_idle; #2;
        n_cmp++; if (Mem_Misalign !== 1'b1) begin n_err++; $display("FAIL mis_pulse got=%b want=1", Mem_Misalign); end
        n_cmp++; if (DMem_Req !== 1'b0) begin n_err++; $display("FAIL mis_noreq got=%b want=0", DMem_Req); end
        tick; #2;
        n_cmp++; if (Mem_Misalign !== 1'b0) begin n_err++; $display("FAIL mis_onecycle got=%b want=0", Mem_Misalign); end
        tick;
    endtask

    task automatic test_timeout;
        int  rq;
        bit  done;
        rq = 0; done = 0;
        set_op(1, 0, 1, MEM_SIZE_W, 0, 32'h300, 0, 5'd6);
        for (int i = 0; i < 12; i++) begin
            tick; #2;
            if (Stall_Mem === 1'b0) begin done = 1; break; end
            rq += int'(DMem_Req);
        end
        n_cmp++; if (!done) begin n_err++; $display("FAIL to_reach_done got=stuck want=done within 12 cycles"); end
        n_cmp++; if (rq !== 4) begin n_err++; $display("FAIL to_reqcycles got=%0d want=4", rq); end
        n_cmp++; if (Mem_Err !== 1'b1 || DMem_Req !== 1'b0) begin n_err++; $display("FAIL to_err got err=%b req=%b want 1/0", Mem_Err, DMem_Req); end
        n_cmp++; if (MEM_RegWrite !== 1'b0 || MEM_ReadMemData !== 32'h0) begin n_err++; $display("FAIL to_wb got rw=%b rd=%h want 0/0", MEM_RegWrite, MEM_ReadMemData); end
        tick; set_idle;
        DMem_Ack = 1; DMem_RData = 32'h55AA55AA;
        tick; DMem_Ack = 0; #2;
        n_cmp++; if (Mem_Err !== 1'b1 || DMem_Req !== 1'b0 || Stall_Mem !== 1'b0) begin n_err++; $display("FAIL to_sticky got err=%b req=%b st=%b want 1/0/0", Mem_Err, DMem_Req, Stall_Mem); end
        tick;
    endtask

    task automatic test_back_to_back;
        int st, rq;
        set_op(1, 0, 1, MEM_SIZE_W, 0, 32'h500, 0, 5'd10);
        run_access(32'h11111111, 0, st, rq);
        tick; set_op(1, 0, 1, MEM_SIZE_W, 0, 32'h504, 0, 5'd11); #1;
        n_cmp++; if (DMem_Req !== 1'b0) begin n_err++; $display("FAIL b2b_gap got=%b want=0", DMem_Req); end
        run_access(32'h22222222, 0, st, rq);
        n_cmp++; if (MEM_ReadMemData !== 32'h22222222 || MEM_WriteRegAddr !== 5'd11 || DMem_Addr !== 32'h504) begin n_err++; $display("FAIL b2b_second got rd=%h wra=%0d addr=%h want 22222222/11/504", MEM_ReadMemData, MEM_WriteRegAddr, DMem_Addr); end
        tick; set_idle;
    endtask

    task automatic test_reset_mid_req;
        set_op(1, 0, 1, MEM_SIZE_W, 0, 32'h400, 0, 5'd12);
        tick; #2;
        n_cmp++; if (DMem_Req !== 1'b1) begin n_err++; $display("FAIL rr_inreq got=%b want=1", DMem_Req); end
        Rst = 1; #1;
        n_cmp++; if (Stall_Mem !== 1'b0 || MEM_RegWrite !== 1'b0) begin n_err++; $display("FAIL rr_hold got st=%b rw=%b want 0/0", Stall_Mem, MEM_RegWrite); end
        tick; #2;
        n_cmp++; if (DMem_Req !== 1'b0 || Mem_Err !== 1'b0) begin n_err++; $display("FAIL rr_after got req=%b err=%b want 0/0", DMem_Req, Mem_Err); end
        Rst = 0; set_idle;
        tick; tick; #2;
        n_cmp++; if (DMem_Req !== 1'b0 || Stall_Mem !== 1'b0 || MEM_RegWrite !== 1'b0) begin n_err++; $display("FAIL rr_abandon got req=%b st=%b rw=%b want 0/0/0", DMem_Req, Stall_Mem, MEM_RegWrite); end
        tick;
    endtask

    initial begin
        test_reset;
        test_passthrough;
        test_word_load;
        test_wait_states;
        test_subword;
        test_misalign;
        test_back_to_back;
        test_timeout;
        test_reset_mid_req;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
